// File: rtl/ep2_port_scheduler_pkg.sv
// Shared types, header field layout and small helpers for the EP2 port scheduler.
// Imported by the scheduler top level and its sub-modules.
package ep2_sched_pkg;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DISCARD = 3'd4
    } sched_state_e;

    localparam int          NUM_PORTS = 4;
    localparam int          PORT_LSB  = 0;
    localparam int          PORT_W    = 2;
    localparam logic [7:0]  RSVD_MASK = 8'hFC;

    function automatic logic [PORT_W-1:0] hdr_port(input logic [7:0] hdr);
        return hdr[PORT_LSB +: PORT_W];
    endfunction

    function automatic logic hdr_rsvd_bad(input logic [7:0] hdr);
        return ((hdr & RSVD_MASK) != 8'h00);
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] port);
        return 4'b0001 << port;
    endfunction

    // Error counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : (val + 8'd1);
    endfunction

endpackage

// File: rtl/ep2_port_scheduler_if.sv
// EP2 byte stream handshake between the FX2 interface (master) and the scheduler (slave).
interface ep2_port_scheduler_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ep2_port_scheduler_fifo_space.sv
// Free space of one tracking FIFO from its binary write/read pointers.
// One slot is always kept empty so equal pointers unambiguously mean empty.
module fifo_space_calc #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    output logic [ADDR_WIDTH-1:0] space
);
    logic [ADDR_WIDTH-1:0] w_used;

    assign w_used = addr_in - addr_out;
    assign space  = {ADDR_WIDTH{1'b1}} - w_used;
endmodule

// File: rtl/ep2_port_scheduler.sv
// Parses framed EP2 packets (header, big-endian length, payload) and steers payload
// bytes to the addressed port FIFO, stalling on low space and dropping bad packets.
module ep2_port_scheduler
    import ep2_sched_pkg::*;
#(
    parameter int ADDR_WIDTH   = 11,
    parameter int SPACE_MARGIN = 2
) (
    input  logic                              ep2_port_clk,
    input  logic                              reset,
    ep2_port_scheduler_if.slave               s_in,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   fifo_addr_in,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   fifo_addr_out,
    input  logic [NUM_PORTS-1:0]              port_enable,
    output logic [7:0]                        ep2_port_data,
    output logic [NUM_PORTS-1:0]              ep2_port_write,
    output logic                              busy,
    output logic [PORT_W-1:0]                 cur_port,
    output logic [7:0]                        err_count
);
    sched_state_e          r_state;
    logic [PORT_W-1:0]     r_port;
    logic                  r_drop;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_remaining;
    logic [7:0]            r_data;
    logic [NUM_PORTS-1:0]  r_write;
    logic [7:0]            r_err;

    logic [ADDR_WIDTH-1:0] w_space [NUM_PORTS];
    logic                  w_in_ready;
    logic                  w_xfer;
    logic [15:0]           w_len;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_space
        fifo_space_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_space (
            .addr_in  (fifo_addr_in [g*ADDR_WIDTH +: ADDR_WIDTH]),
            .addr_out (fifo_addr_out[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .space    (w_space[g])
        );
    end

    // Ready depends only on registered state and pointers; the margin absorbs pointer lag.
    always_comb begin
        w_in_ready = 1'b1;
        case (r_state)
            ST_PAYLOAD: w_in_ready = (w_space[r_port] >= ADDR_WIDTH'(SPACE_MARGIN));
            default:    w_in_ready = 1'b1;
        endcase
    end

    assign s_in.in_ready = w_in_ready;
    assign w_xfer        = s_in.in_valid & w_in_ready;
    assign w_len         = {r_len_hi, s_in.in_data};

    // Packet parser FSM with the registered write port and error counter.
    always_ff @(posedge ep2_port_clk) begin
        if (reset) begin
            r_state     <= ST_HDR;
            r_port      <= {PORT_W{1'b0}};
            r_drop      <= 1'b0;
            r_len_hi    <= 8'h00;
            r_remaining <= 16'h0000;
            r_data      <= 8'h00;
            r_write     <= {NUM_PORTS{1'b0}};
            r_err       <= 8'h00;
        end else begin
            r_write <= {NUM_PORTS{1'b0}};
            case (r_state)
                ST_HDR: begin
                    if (w_xfer) begin
                        r_port  <= hdr_port(s_in.in_data);
                        r_drop  <= hdr_rsvd_bad(s_in.in_data) |
                                   ~port_enable[hdr_port(s_in.in_data)];
                        r_state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= s_in.in_data;
                        r_state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_remaining <= w_len;
                        if (w_len == 16'h0000) begin
                            r_state <= ST_HDR;
                            if (r_drop) begin
                                r_err <= sat_inc8(r_err);
                            end
                        end else if (r_drop) begin
                            r_state <= ST_DISCARD;
                        end else begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        r_data      <= s_in.in_data;
                        r_write     <= port_onehot(r_port);
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= ST_HDR;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_xfer) begin
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= ST_HDR;
                            r_err   <= sat_inc8(r_err);
                        end
                    end
                end
                default: begin
                    r_state <= ST_HDR;
                end
            endcase
        end
    end

    assign ep2_port_data  = r_data;
    assign ep2_port_write = r_write;
    assign busy           = (r_state != ST_HDR);
    assign cur_port       = r_port;
    assign err_count      = r_err;
endmodule

// File: tb/tb_ep2_port_scheduler.sv
// Directed self-checking bench for ep2_port_scheduler with hand-computed expectations.
module tb_ep2_port_scheduler;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [4*AW-1:0] addr_in;
    logic [4*AW-1:0] addr_out;
    logic [3:0]    port_enable;
    logic [7:0]    data;
    logic [3:0]    wr;
    logic          busy;
    logic [1:0]    cur_port;
    logic [7:0]    err_count;
    int            total = 0;
    int            bad   = 0;

    ep2_port_scheduler_if u_if ();

    ep2_port_scheduler #(.ADDR_WIDTH(AW), .SPACE_MARGIN(2)) dut (
        .ep2_port_clk   (clk),
        .reset          (reset),
        .s_in           (u_if),
        .fifo_addr_in   (addr_in),
        .fifo_addr_out  (addr_out),
        .port_enable    (port_enable),
        .ep2_port_data  (data),
        .ep2_port_write (wr),
        .busy           (busy),
        .cur_port       (cur_port),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic set_ptr(input int p, input logic [AW-1:0] ai, input logic [AW-1:0] ao);
        addr_in [p*AW +: AW] = ai;
        addr_out[p*AW +: AW] = ao;
    endtask

    // Offer one byte, wait (bounded) for ready, return #1 after the accepting edge.
    task automatic xfer(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        u_if.in_data  = b;
        u_if.in_valid = 1'b1;
        while (u_if.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 64) begin
            bad++;
            $display("FAIL xfer_ready byte=%h got=%b exp=1", b, u_if.in_ready);
        end
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        u_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({u_if.in_ready, wr, data, busy, cur_port, err_count} !== {1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 8'h00}) begin
            bad++;
            $display("FAIL reset_vals got rdy=%b wr=%b d=%h busy=%b port=%0d err=%0d exp rdy=1 wr=0000 d=00 busy=0 port=0 err=0",
                     u_if.in_ready, wr, data, busy, cur_port, err_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] pl [3];
        pl[0] = 8'hA1; pl[1] = 8'hA2; pl[2] = 8'hA3;
        xfer(8'h01);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        xfer(8'h00);
        xfer(8'h03);
        for (int i = 0; i < 3; i++) begin
            xfer(pl[i]);
            total++;
            if (wr !== 4'b0010 || data !== pl[i]) begin
                bad++;
                $display("FAIL basic_byte%0d got wr=%b d=%h exp wr=0010 d=%h", i, wr, data, pl[i]);
            end
        end
        total++;
        if (busy !== 1'b0 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL basic_end got busy=%b err=%0d exp busy=0 err=0", busy, err_count);
        end
        @(posedge clk);
        #1;
        total++;
        if (wr !== 4'b0000) begin bad++; $display("FAIL basic_idle_wr got=%b exp=0000", wr); end
    endtask

    task automatic test_backpressure();
        set_ptr(2, 11'd2045, 11'd0);
        xfer(8'h02);
        xfer(8'h00);
        xfer(8'h04);
        xfer(8'hB1);
        total++;
        if (wr !== 4'b0100 || data !== 8'hB1) begin
            bad++; $display("FAIL bp_b1 got wr=%b d=%h exp wr=0100 d=b1", wr, data);
        end
        @(negedge clk);
        set_ptr(2, 11'd2046, 11'd0);
        u_if.in_data  = 8'hB2;
        u_if.in_valid = 1'b1;
        #1;
        total++;
        if (u_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", u_if.in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (wr !== 4'b0000 || busy !== 1'b1) begin
                bad++; $display("FAIL bp_stall%0d got wr=%b busy=%b exp wr=0000 busy=1", i, wr, busy);
            end
        end
        @(negedge clk);
        set_ptr(2, 11'd2046, 11'd3);
        #1;
        total++;
        if (u_if.in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_ready got=%b exp=1", u_if.in_ready); end
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        total++;
        if (wr !== 4'b0100 || data !== 8'hB2) begin
            bad++; $display("FAIL bp_b2 got wr=%b d=%h exp wr=0100 d=b2", wr, data);
        end
        set_ptr(2, 11'd2047, 11'd3);
        xfer(8'hB3);
        total++;
        if (wr !== 4'b0100 || data !== 8'hB3) begin
            bad++; $display("FAIL bp_b3 got wr=%b d=%h exp wr=0100 d=b3", wr, data);
        end
        set_ptr(2, 11'd0, 11'd3);
        xfer(8'hB4);
        total++;
        if (wr !== 4'b0100 || data !== 8'hB4 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_b4 got wr=%b d=%h busy=%b exp wr=0100 d=b4 busy=0", wr, data, busy);
        end
    endtask

    task automatic test_reserved_drop();
        xfer(8'h05);
        xfer(8'h00);
        xfer(8'h02);
        xfer(8'h11);
        total++;
        if (wr !== 4'b0000) begin bad++; $display("FAIL drop_b0 got wr=%b exp=0000", wr); end
        xfer(8'h22);
        total++;
        if (wr !== 4'b0000 || err_count !== 8'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL drop_b1 got wr=%b err=%0d busy=%b exp wr=0000 err=1 busy=0", wr, err_count, busy);
        end
        xfer(8'h03);
        xfer(8'h00);
        xfer(8'h01);
        xfer(8'h33);
        total++;
        if (wr !== 4'b1000 || data !== 8'h33 || cur_port !== 2'd3) begin
            bad++; $display("FAIL drop_p3 got wr=%b d=%h port=%0d exp wr=1000 d=33 port=3", wr, data, cur_port);
        end
    endtask

    task automatic test_disabled_len0();
        do_reset();
        port_enable = 4'b1110;
        xfer(8'h00);
        xfer(8'h00);
        xfer(8'h00);
        total++;
        if (err_count !== 8'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL dis_len0 got err=%0d busy=%b exp err=1 busy=0", err_count, busy);
        end
        xfer(8'h01);
        port_enable = 4'b0000;
        xfer(8'h00);
        xfer(8'h01);
        xfer(8'h44);
        total++;
        if (wr !== 4'b0010 || data !== 8'h44 || err_count !== 8'd1) begin
            bad++; $display("FAIL dis_b2b got wr=%b d=%h err=%0d exp wr=0010 d=44 err=1", wr, data, err_count);
        end
        port_enable = 4'b1111;
    endtask

    task automatic test_wrap_reset();
        addr_in  = '0;
        addr_out = '0;
        set_ptr(0, 11'h7FF, 11'h7FE);
        xfer(8'h00);
        xfer(8'h00);
        xfer(8'h05);
        xfer(8'hC1);
        total++;
        if (wr !== 4'b0001 || data !== 8'hC1) begin
            bad++; $display("FAIL wrap_c1 got wr=%b d=%h exp wr=0001 d=c1", wr, data);
        end
        xfer(8'hC2);
        total++;
        if (wr !== 4'b0001 || data !== 8'hC2) begin
            bad++; $display("FAIL wrap_c2 got wr=%b d=%h exp wr=0001 d=c2", wr, data);
        end
        @(negedge clk);
        reset = 1'b1;
        u_if.in_data  = 8'hC3;
        u_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({u_if.in_ready, wr, data, busy, cur_port, err_count} !== {1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 8'h00}) begin
            bad++;
            $display("FAIL midreset got rdy=%b wr=%b d=%h busy=%b port=%0d err=%0d exp rdy=1 wr=0000 d=00 busy=0 port=0 err=0",
                     u_if.in_ready, wr, data, busy, cur_port, err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        u_if.in_valid = 1'b0;
        xfer(8'h01);
        total++;
        if (cur_port !== 2'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL post_reset_hdr got port=%0d busy=%b exp port=1 busy=1", cur_port, busy);
        end
        xfer(8'h00);
        xfer(8'h01);
        xfer(8'hD1);
        total++;
        if (wr !== 4'b0010 || data !== 8'hD1 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_pl got wr=%b d=%h busy=%b exp wr=0010 d=d1 busy=0", wr, data, busy);
        end
    endtask

    initial begin
        addr_in       = '0;
        addr_out      = '0;
        port_enable   = 4'b1111;
        u_if.in_data  = 8'h00;
        u_if.in_valid = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reserved_drop();
        test_disabled_len0();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
